// File: rtl/prog_loader_if.sv
// Host byte link plus program-memory write port for prog_loader.
// slave = loader side, master = host/memory side.
interface prog_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [13:0]       pm_wdata;

  modport slave  (input in_valid, in_data, output in_ready, pm_we, pm_addr, pm_wdata);
  modport master (output in_valid, in_data, input in_ready, pm_we, pm_addr, pm_wdata);
endinterface

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader: fills 14-bit program memory, then releases the CPU.
// Optional trailing mod-256 checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus,
  input  logic          reload,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);
  localparam int          DEPTH   = 2 ** ADDR_W;
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  localparam logic [2:0] CNT_HI = 3'd0;
  localparam logic [2:0] CNT_LO = 3'd1;
  localparam logic [2:0] W_HI   = 3'd2;
  localparam logic [2:0] W_LO   = 3'd3;
  localparam logic [2:0] RUN    = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHK    = 3'd4;
  localparam logic [2:0] AFTER_LAST = CHK;
`else
  localparam logic [2:0] AFTER_LAST = RUN;
`endif

  logic [2:0]        state;
  logic [7:0]        cnt_hi;
  logic [15:0]       count;
  logic [ADDR_W-1:0] idx;
  logic [5:0]        w_hi;
  logic              accept;
  logic [15:0]       n_new;
  logic              last_word;
  logic              restart;

  always_comb begin
    bus.in_ready = 1'b0;
    if (!reset) begin
      case (state)
        CNT_HI, CNT_LO, W_HI, W_LO: bus.in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK:                        bus.in_ready = 1'b1;
`endif
        default:                    bus.in_ready = 1'b0;
      endcase
    end
  end

  assign accept    = bus.in_valid && bus.in_ready;
  assign n_new     = {cnt_hi, bus.in_data};
  // 17-bit compare so N-1 never underflows into a false match; N>=1 here anyway.
  assign last_word = ({{(17-ADDR_W){1'b0}}, idx} == ({1'b0, count} - 17'd1));
  assign restart   = reload && ((state == RUN) || (state == ERR));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] acc;

  always_ff @(posedge clk) begin
    if (reset || restart)              acc <= 8'd0;
    else if (accept && state != CHK)   acc <= acc + bus.in_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CNT_HI;
      cnt_hi       <= 8'd0;
      count        <= 16'd0;
      idx          <= '0;
      w_hi         <= 6'd0;
      bus.pm_we    <= 1'b0;
      bus.pm_addr  <= '0;
      bus.pm_wdata <= 14'd0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      bus.pm_we <= 1'b0;
      case (state)
        CNT_HI: if (accept) begin
          cnt_hi <= bus.in_data;
          state  <= CNT_LO;
        end
        CNT_LO: if (accept) begin
          count <= n_new;
          idx   <= '0;
          if (n_new == 16'd0 || {1'b0, n_new} > DEPTH17) state <= ERR;
          else                                           state <= W_HI;
        end
        W_HI: if (accept) begin
          w_hi  <= bus.in_data[5:0];
          state <= W_LO;
        end
        W_LO: if (accept) begin
          bus.pm_we    <= 1'b1;
          bus.pm_addr  <= idx;
          bus.pm_wdata <= {w_hi, bus.in_data};
          if (last_word) state <= AFTER_LAST;
          else begin
            idx   <= idx + 1'b1;
            state <= W_HI;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: if (accept) state <= (bus.in_data == acc) ? RUN : ERR;
`endif
        RUN: begin
          // Release lands one edge after RUN entry, so the final pm_we has retired.
          cpu_reset <= 1'b0;
          done      <= 1'b1;
          if (reload) begin
            state     <= CNT_HI;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            idx       <= '0;
          end
        end
        ERR: begin
          error <= 1'b1;
          if (reload) begin
            state     <= CNT_HI;
            cpu_reset <= 1'b1;
            error     <= 1'b0;
            idx       <= '0;
          end
        end
        default: state <= CNT_HI;
      endcase
    end
  end
endmodule
